// File: rtl/mux8_1.sv
// Eight-input selector: combinational output O plus an enable-loaded registered copy Q.
// WIDTH sets the data width only; the select is always the three bits {S2,S1,S0}.
module mux8_1 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] Q
);

    logic [2:0]       w_sel;
    logic [WIDTH-1:0] w_in [8];
    logic [WIDTH-1:0] r_q;

    assign w_sel = {S2, S1, S0};

    assign w_in[0] = I0;
    assign w_in[1] = I1;
    assign w_in[2] = I2;
    assign w_in[3] = I3;
    assign w_in[4] = I4;
    assign w_in[5] = I5;
    assign w_in[6] = I6;
    assign w_in[7] = I7;

    // Array indexing gives X on O in simulation when a select bit is X/Z.
    assign O = w_in[w_sel];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q <= '0;
        end else if (EN) begin
            r_q <= O;
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_mux8_1.sv
// Self-checking bench for mux8_1: table vectors at WIDTH=1, bus words and random
// traffic at WIDTH=16, plus hand-written reset and enable sequences.
module tb_mux8_1;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  sel;
    logic [7:0]  b1;
    logic [15:0] w16 [8];
    logic        o1, q1;
    logic [15:0] o16, q16;

    int total;
    int bad;

    mux8_1 #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .EN(en),
        .S0(sel[0]), .S1(sel[1]), .S2(sel[2]),
        .I0(b1[0]), .I1(b1[1]), .I2(b1[2]), .I3(b1[3]),
        .I4(b1[4]), .I5(b1[5]), .I6(b1[6]), .I7(b1[7]),
        .O(o1), .Q(q1)
    );

    mux8_1 #(.WIDTH(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .EN(en),
        .S0(sel[0]), .S1(sel[1]), .S2(sel[2]),
        .I0(w16[0]), .I1(w16[1]), .I2(w16[2]), .I3(w16[3]),
        .I4(w16[4]), .I5(w16[5]), .I6(w16[6]), .I7(w16[7]),
        .O(o16), .Q(q16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] bits;
        logic       exp_o;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge, well clear of setup/hold.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: concatenate the eight words and pick the slot by arithmetic offset.
    function automatic logic [15:0] ref_pick(input logic [2:0] s);
        logic [127:0] flat;
        flat = {w16[7], w16[6], w16[5], w16[4], w16[3], w16[2], w16[1], w16[0]};
        return flat[int'(s) * 16 +: 16];
    endfunction

    logic [15:0] exp_q;
    logic [15:0] exp_o;
    logic        walk_exp [8];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 3'd0;
        b1    = 8'h00;
        for (int k = 0; k < 8; k++) w16[k] = '0;

        walk_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 8; s++)
            vecs.push_back('{sel: 3'(s), bits: 8'b1010_1010, exp_o: walk_exp[s]});
        for (int k = 0; k < 8; k++)
            for (int s = 0; s < 8; s++)
                vecs.push_back('{sel: 3'(s), bits: 8'(1 << k), exp_o: (k == s)});

        #2;
        check("reset_q1", {15'd0, q1}, 16'd0);
        check("reset_q16", q16, 16'd0);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            b1  = vecs[i].bits;
            #5;
            check($sformatf("vec%0d_o1", i), {15'd0, o1}, {15'd0, vecs[i].exp_o});
        end

        // Bus words 1111,2222,...,8888: no bit mixing between inputs.
        for (int k = 0; k < 8; k++) w16[k] = 16'h1111 * 16'(k + 1);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #5;
            check($sformatf("bus_sel%0d", s), o16, 16'h1111 * 16'(s + 1));
        end

        // O stays valid while held in reset.
        sel = 3'd6;
        #1;
        check("o_in_reset", o16, 16'h7777);

        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        check("q_hold_after_rst", q16, 16'd0);

        b1    = 8'b0000_1000;
        sel   = 3'd3;
        en    = 1'b1;
        tick();
        check("q_load_sel3", {15'd0, q1}, 16'd1);
        check("q16_load_sel3", q16, 16'h4444);

        en  = 1'b0;
        sel = 3'd2;
        for (int e = 0; e < 3; e++) begin
            tick();
            check($sformatf("q_hold_edge%0d", e), {15'd0, q1}, 16'd1);
        end

        // Async reset between edges, with O still following I[sel].
        sel = 3'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q1", {15'd0, q1}, 16'd0);
        check("async_rst_q16", q16, 16'd0);
        check("async_rst_o1", {15'd0, o1}, 16'd1);

        en = 1'b1;
        tick();
        check("rst_blocks_load", {15'd0, q1}, 16'd0);
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        check("no_load_en0", {15'd0, q1}, 16'd0);

        exp_q = 16'd0;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 8; k++) w16[k] = 16'($urandom);
            sel = 3'($urandom_range(0, 7));
            en  = ($urandom_range(0, 3) != 0);
            #1;
            exp_o = ref_pick(sel);
            check($sformatf("rnd%0d_o", n), o16, exp_o);
            if (en) exp_q = exp_o;
            tick();
            check($sformatf("rnd%0d_q", n), q16, exp_q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
